// File: rtl/sipo_32x16.sv
// sipo_32x16: serial-in, parallel-out frame assembler.
// Collects 32 qualified samples of a signed stream and presents them as one
// frame on d_out0..d_out31. The frame completes with a one-cycle done strobe.
// The 32nd sample goes straight from d_in to d_out31. This lets the new frame
// appear on the same edge that accepts it.

module sipo_32x16 #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_ready,
  input  logic signed [WIDTH-1:0] d_in,
  output logic signed [WIDTH-1:0] d_out0,
  output logic signed [WIDTH-1:0] d_out1,
  output logic signed [WIDTH-1:0] d_out2,
  output logic signed [WIDTH-1:0] d_out3,
  output logic signed [WIDTH-1:0] d_out4,
  output logic signed [WIDTH-1:0] d_out5,
  output logic signed [WIDTH-1:0] d_out6,
  output logic signed [WIDTH-1:0] d_out7,
  output logic signed [WIDTH-1:0] d_out8,
  output logic signed [WIDTH-1:0] d_out9,
  output logic signed [WIDTH-1:0] d_out10,
  output logic signed [WIDTH-1:0] d_out11,
  output logic signed [WIDTH-1:0] d_out12,
  output logic signed [WIDTH-1:0] d_out13,
  output logic signed [WIDTH-1:0] d_out14,
  output logic signed [WIDTH-1:0] d_out15,
  output logic signed [WIDTH-1:0] d_out16,
  output logic signed [WIDTH-1:0] d_out17,
  output logic signed [WIDTH-1:0] d_out18,
  output logic signed [WIDTH-1:0] d_out19,
  output logic signed [WIDTH-1:0] d_out20,
  output logic signed [WIDTH-1:0] d_out21,
  output logic signed [WIDTH-1:0] d_out22,
  output logic signed [WIDTH-1:0] d_out23,
  output logic signed [WIDTH-1:0] d_out24,
  output logic signed [WIDTH-1:0] d_out25,
  output logic signed [WIDTH-1:0] d_out26,
  output logic signed [WIDTH-1:0] d_out27,
  output logic signed [WIDTH-1:0] d_out28,
  output logic signed [WIDTH-1:0] d_out29,
  output logic signed [WIDTH-1:0] d_out30,
  output logic signed [WIDTH-1:0] d_out31,
  output logic                    done
);

  // Slot index of the next sample to be accepted; wraps naturally after 31.
  logic [4:0] count;

  // Only slots 0..30 need storage; the last sample bypasses into the frame.
  logic signed [WIDTH-1:0] buffer [0:30];

  // Registered copy of the last completed frame.
  logic signed [WIDTH-1:0] frame [0:32-1];

  // Accept qualified samples, and publish the whole frame on the 32nd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 5'd0;
      done  <= 1'b0;
      for (int i = 0; i < 31; i++) buffer[i] <= '0;
      for (int i = 0; i < 32; i++) frame[i]  <= '0;
    end else begin
      done <= 1'b0;
      if (in_ready) begin
        count <= count + 5'd1;
        if (count == 5'd31) begin
          for (int i = 0; i < 31; i++) frame[i] <= buffer[i];
          frame[31] <= d_in;
          done      <= 1'b1;
        end else begin
          for (int i = 0; i < 31; i++) begin
            if (count == 5'(i)) buffer[i] <= d_in;
          end
        end
      end
    end
  end

  assign d_out0  = frame[0];
  assign d_out1  = frame[1];
  assign d_out2  = frame[2];
  assign d_out3  = frame[3];
  assign d_out4  = frame[4];
  assign d_out5  = frame[5];
  assign d_out6  = frame[6];
  assign d_out7  = frame[7];
  assign d_out8  = frame[8];
  assign d_out9  = frame[9];
  assign d_out10 = frame[10];
  assign d_out11 = frame[11];
  assign d_out12 = frame[12];
  assign d_out13 = frame[13];
  assign d_out14 = frame[14];
  assign d_out15 = frame[15];
  assign d_out16 = frame[16];
  assign d_out17 = frame[17];
  assign d_out18 = frame[18];
  assign d_out19 = frame[19];
  assign d_out20 = frame[20];
  assign d_out21 = frame[21];
  assign d_out22 = frame[22];
  assign d_out23 = frame[23];
  assign d_out24 = frame[24];
  assign d_out25 = frame[25];
  assign d_out26 = frame[26];
  assign d_out27 = frame[27];
  assign d_out28 = frame[28];
  assign d_out29 = frame[29];
  assign d_out30 = frame[30];
  assign d_out31 = frame[31];

endmodule

// File: tb/tb_sipo_32x16.sv
// tb_sipo_32x16: directed test of the 32-sample serial-to-parallel framer.
// The test covers the following cases:
// - the reset state
// - a plain frame
// - a frame with an in_ready gap
// - signed extreme values
// - an asynchronous reset in the middle of a frame
// - back-to-back frames

module tb_sipo_32x16;

  logic               clk;
  logic               rst;
  logic               in_ready;
  logic signed [15:0] d_in;
  logic signed [15:0] dout [0:31];
  logic               done;

  int vectors;
  int miscompares;

  sipo_32x16 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_ready(in_ready), .d_in(d_in),
    .d_out0(dout[0]),   .d_out1(dout[1]),   .d_out2(dout[2]),   .d_out3(dout[3]),
    .d_out4(dout[4]),   .d_out5(dout[5]),   .d_out6(dout[6]),   .d_out7(dout[7]),
    .d_out8(dout[8]),   .d_out9(dout[9]),   .d_out10(dout[10]), .d_out11(dout[11]),
    .d_out12(dout[12]), .d_out13(dout[13]), .d_out14(dout[14]), .d_out15(dout[15]),
    .d_out16(dout[16]), .d_out17(dout[17]), .d_out18(dout[18]), .d_out19(dout[19]),
    .d_out20(dout[20]), .d_out21(dout[21]), .d_out22(dout[22]), .d_out23(dout[23]),
    .d_out24(dout[24]), .d_out25(dout[25]), .d_out26(dout[26]), .d_out27(dout[27]),
    .d_out28(dout[28]), .d_out29(dout[29]), .d_out30(dout[30]), .d_out31(dout[31]),
    .done(done)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input, then settle just after the rising edge.
  task automatic applyStimulus(input logic r, input logic [15:0] d);
    in_ready = r;
    d_in     = d;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // The whole frame should read base, base+step, base+2*step, ...
  task automatic checkFrame(input string tag, input int base, input int step);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("%s d_out%0d", tag, i), dout[i], 16'(base + i * step));
  endtask

  // Check the done strobe and the slot counter.
  task automatic checkCtl(input string tag, input logic exp_done, input int exp_count);
    checkOutput({tag, " done"}, {15'd0, done}, {15'd0, exp_done});
    checkOutput({tag, " count"}, {11'd0, dut.count}, 16'(exp_count));
  endtask

  function automatic logic [15:0] signedPattern(input int i);
    case (i % 3)
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      default: return 16'h7FFF;
    endcase
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_ready    = 1'b0;
    d_in        = '0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    checkFrame("reset", 0, 0);
    checkCtl("reset", 1'b0, 0);
    rst = 1'b0;

    // First frame 1..32: outputs stay zero until the 32nd sample
    for (int k = 1; k <= 31; k++) begin
      applyStimulus(1'b1, 16'(k));
      checkFrame($sformatf("fill%0d", k), 0, 0);
      checkCtl($sformatf("fill%0d", k), 1'b0, k);
    end
    applyStimulus(1'b1, 16'd32);
    checkFrame("frame1", 1, 1);
    checkCtl("frame1", 1'b1, 0);
    applyStimulus(1'b0, 16'd77);
    checkCtl("frame1 idle", 1'b0, 0);
    checkFrame("frame1 idle", 1, 1);

    // Signed extremes are stored bit-exact
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, signedPattern(i));
      if (i < 31) checkOutput("signed hold d_out0", dout[0], 16'd1);
    end
    checkCtl("signed", 1'b1, 0);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("signed d_out%0d", i), dout[i], signedPattern(i));

    // Gap of three in_ready=0 cycles after sample 10, with junk data on d_in
    for (int k = 1; k <= 10; k++) applyStimulus(1'b1, 16'(k));
    for (int g = 0; g < 3; g++) begin
      applyStimulus(1'b0, 16'd99);
      checkCtl($sformatf("gap%0d", g), 1'b0, 10);
    end
    for (int k = 11; k <= 31; k++) applyStimulus(1'b1, 16'(k));
    checkCtl("gap pre-done", 1'b0, 31);
    checkOutput("gap hold d_out0", dout[0], 16'hFFFF);
    applyStimulus(1'b1, 16'd32);
    checkCtl("gap frame", 1'b1, 0);
    checkFrame("gap frame", 1, 1);

    // Asynchronous reset after sample 20 discards the partial frame
    for (int k = 1; k <= 20; k++) applyStimulus(1'b1, 16'(200 + k));
    checkCtl("pre-reset", 1'b0, 20);
    #1 rst = 1'b1;
    #1;
    checkFrame("async reset", 0, 0);
    checkCtl("async reset", 1'b0, 0);
    #1 rst = 1'b0;
    for (int k = 101; k <= 132; k++) applyStimulus(1'b1, 16'(k));
    checkCtl("post-reset frame", 1'b1, 0);
    checkOutput("post-reset d_out0", dout[0], 16'd101);
    checkOutput("post-reset d_out31", dout[31], 16'd132);
    checkFrame("post-reset frame", 101, 1);

    // Back-to-back frames 1..32 then 33..64
    for (int k = 1; k <= 64; k++) begin
      applyStimulus(1'b1, 16'(k));
      if (k == 32) begin
        checkCtl("b2b first", 1'b1, 0);
        checkFrame("b2b first", 1, 1);
      end else if (k > 32 && k < 64) begin
        checkCtl($sformatf("b2b hold%0d", k), 1'b0, k - 32);
        checkOutput($sformatf("b2b hold%0d d_out0", k), dout[0], 16'd1);
        checkOutput($sformatf("b2b hold%0d d_out31", k), dout[31], 16'd32);
      end
    end
    checkCtl("b2b second", 1'b1, 0);
    checkFrame("b2b second", 33, 1);
    applyStimulus(1'b1, 16'd500);
    checkCtl("b2b after", 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sipo_32x16.md
SIPO_32X16 -- requirements
Module: sipo_32x16

Interface
REQ-001 Parameter: WIDTH, default 16, sample width in bits (two's-complement signed).
REQ-002 Port: clk  input  1  rising-edge system clock; the block has one clock.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_ready  input  1  sample-valid qualifier; d_in is captured only on rising clk edges where in_ready=1.
REQ-005 Port: d_in  input  WIDTH (signed)  serial sample stream.
REQ-006 Port: d_out0 .. d_out31  output  WIDTH each (signed)  parallel frame words, d_outN = N-th sample of the last completed frame (d_out0 = first sample).
REQ-007 Port: done  output  1  frame-complete strobe.
REQ-008 Internal frame index register SHALL be named count, 5 bits, visible hierarchically for debug.

Function
REQ-009 On each rising clk edge with in_ready=1, the block SHALL write d_in into internal buffer slot count and increment count by 1.
REQ-010 On rising clk edges with in_ready=0, the block SHALL hold count, buffer, outputs and done unchanged, except that done returns to 0.
REQ-011 Captured samples SHALL be stored bit-exact; no sign extension, truncation or arithmetic.
REQ-012 On the capture edge where count=31, i.e. the 32nd accepted sample:
- all 32 outputs SHALL update simultaneously: slots 0..30 from the buffer, d_out31 from the current d_in;
- done SHALL be 1 for exactly the following cycle;
- count SHALL wrap to 0.
REQ-013 Outputs SHALL change only at frame completion; during frame accumulation they hold the previous frame.
REQ-014 Latency: done and the new d_out values SHALL be visible immediately after the clock edge that captures the 32nd sample, with zero additional cycles.
REQ-015 in_ready gaps mid-frame SHALL NOT discard or reorder samples; accumulation resumes at the held count.
REQ-016 Back-to-back frames SHALL be supported: the sample accepted on the edge following completion is stored as sample 0 of the next frame.
REQ-017 done SHALL never remain high for two consecutive cycles; with continuous in_ready it pulses once per 32 cycles.

Reset
REQ-018 While rst=1, regardless of clk: count=0, done=0, all d_outN=0, buffer cleared to 0.
REQ-019 A reset asserted mid-frame SHALL discard the partial frame; after rst deasserts, the next accepted sample is sample 0.
REQ-020 The first rising clk edge after rst deasserts SHALL perform normal operation per REQ-009/REQ-010.

Verification
REQ-021 Reset then in_ready=1, d_in=1..32 on 32 consecutive edges -> after the 32nd edge d_out0..d_out31 = 1..32, done=1 for one cycle, count=0.
REQ-022 In the first frame, sample d_out0..31 after each of the first 31 edges -> all remain 0 and done=0; count steps 1..31.
REQ-023 Same stream with in_ready=0 for 3 cycles after sample 10 (d_in changing to 99 during the gap) -> result identical to REQ-021, with no 99 captured; done occurs 3 cycles later.
REQ-024 Signed data: d_in = -1, -32768, 32767 repeating -> outputs reproduce the exact bit patterns (0xFFFF, 0x8000, 0x7FFF).
REQ-025 Reset pulse asserted asynchronously after sample 20 -> outputs, done and count go to 0 immediately; a fresh 32-sample frame 101..132 yields d_out0=101 and d_out31=132.
REQ-026 Two back-to-back frames 1..32 then 33..64 -> done pulses at cycles 32 and 64; the second frame shows d_out0=33 and d_out31=64; the first frame is held during cycles 33..63.
